// File: rtl/fp_pkg.sv
// fp_pkg: IEEE-754 single-precision field widths and packed word type shared by FP blocks.
package fp_pkg;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;
    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;
endpackage

// File: rtl/int_to_fp_if.sv
// int_to_fp_if: valid-qualified fixed-point in / float out streaming bus.
interface int_to_fp_if;
    import fp_pkg::*;
    logic        in_vld;
    logic [31:0] din;
    logic        out_vld;
    fp32_t       dout;
    modport master (output in_vld, din, input out_vld, dout);
    modport slave  (input in_vld, din, output out_vld, dout);
endinterface

// File: rtl/lzc32.sv
// lzc32: leading-one detector returning the highest set bit index and an all-zero flag.
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  msb,
    output logic        zero
);
    always_comb begin
        msb = '0;
        for (int i = 0; i < 32; i++)
            if (a[i]) msb = 5'(i);
        zero = ~|a;
    end
endmodule

// File: rtl/int_to_fp.sv
// int_to_fp: 4-stage signed fixed-point to IEEE-754 single converter with round-to-nearest-even.
module int_to_fp
    import fp_pkg::*;
#(
    parameter int FRAC_BITS = 0
) (
    input logic        clk,
    input logic        rst,
    int_to_fp_if.slave bus
);
    logic [3:0]  vld;
    logic        s1_sign;
    logic [31:0] s1_mag;
    logic        s2_sign, s2_zero;
    logic [31:0] s2_mag;
    logic [4:0]  s2_msb;
    logic        s3_sign, s3_zero;
    logic [31:0] s3_norm;
    logic [7:0]  s3_exp;
    logic [4:0]  lz_msb;
    logic        lz_zero;
    logic        rnd;
    logic [24:0] sum;
    fp32_t       res, dout_q;

    lzc32 u_lzc (.a(s1_mag), .msb(lz_msb), .zero(lz_zero));

    // A carry out of the 24-bit significand means it rounded up to the next power of two.
    always_comb begin
        rnd = s3_norm[7] & (|s3_norm[6:0] | s3_norm[8]);
        sum = {1'b0, s3_norm[31:8]} + 25'(rnd);
        res = s3_zero ? '0 : {s3_sign, sum[24] ? s3_exp + 8'd1 : s3_exp, sum[24] ? 23'd0 : sum[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_mag  <= '0;
            s2_msb  <= '0;
            s3_sign <= 1'b0;
            s3_zero <= 1'b0;
            s3_norm <= '0;
            s3_exp  <= '0;
            dout_q  <= '0;
        end else begin
            vld     <= {vld[2:0], bus.in_vld};
            s1_sign <= bus.din[31];
            s1_mag  <= bus.din[31] ? -bus.din : bus.din;
            s2_sign <= s1_sign;
            s2_zero <= lz_zero;
            s2_mag  <= s1_mag;
            s2_msb  <= lz_msb;
            s3_sign <= s2_sign;
            s3_zero <= s2_zero;
            s3_norm <= s2_mag << (5'd31 - s2_msb);
            s3_exp  <= 8'(FP_BIAS - FRAC_BITS + int'(s2_msb));
            dout_q  <= res;
        end
    end

    assign bus.out_vld = vld[3];
    assign bus.dout    = dout_q;
endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp: scoreboard bench driving FRAC_BITS=0 and FRAC_BITS=16 converters side by side.
module tb_int_to_fp;
    typedef struct {
        logic [31:0] v;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q16[$];

    int_to_fp_if b0 ();
    int_to_fp_if b16 ();

    int_to_fp #(.FRAC_BITS(0))  u0  (.clk(clk), .rst(rst), .bus(b0.slave));
    int_to_fp #(.FRAC_BITS(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Independent reference: real-valued scaling, then explicit nearest-even rounding.
    function automatic logic [31:0] ref_fp(logic [31:0] d, int fb);
        real x, m, f;
        int  e;
        logic s;
        if (d == 32'h0) return 32'h0;
        s = d[31];
        x = s ? -$itor($signed(d)) : $itor($signed(d));
        for (int k = 0; k < fb; k++) x = x / 2.0;
        e = 0;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0) begin x = x * 2.0; e--; end
        m = x * 8388608.0;
        f = $floor(m);
        if ((m - f > 0.5) || ((m - f == 0.5) && ($rtoi(f) % 2 == 1))) f = f + 1.0;
        if (f >= 16777216.0) begin f = 8388608.0; e++; end
        return {s, 8'(e + 127), 23'($rtoi(f) - 8388608)};
    endfunction

    task automatic send(logic v0, logic [31:0] d0, logic [31:0] e0,
                        logic v16, logic [31:0] d16, logic [31:0] e16);
        @(posedge clk);
        #1;
        b0.in_vld  = v0;
        b0.din     = d0;
        b16.in_vld = v16;
        b16.din    = d16;
        if (v0)  q0.push_back('{e0, cyc});
        if (v16) q16.push_back('{e16, cyc});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b0.out_vld) begin
            if (q0.size() == 0) chk("f0_unexpected_vld", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("f0_data", b0.dout, e.v);
                chk("f0_latency", 32'(cyc - e.c), 32'd4);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b16.out_vld) begin
            if (q16.size() == 0) chk("f16_unexpected_vld", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                chk("f16_data", b16.dout, e.v);
                chk("f16_latency", 32'(cyc - e.c), 32'd4);
            end
        end
    end

    logic [31:0] d0v[11] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd16777217,
                             32'd16777219, 32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFB, 32'd2, 32'd1000};
    logic [31:0] e0v[11] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0, 32'hCF00_0000, 32'h4B80_0000,
                             32'h4B80_0002, 32'h4F00_0000, 32'h4040_0000, 32'hC0A0_0000,
                             32'h4000_0000, 32'h447A_0000};
    logic [31:0] d16v[4] = '{32'h0001_8000, 32'hFFFF_0000, 32'h0000_0001, 32'h0};
    logic [31:0] e16v[4] = '{32'h3FC0_0000, 32'hBF80_0000, 32'h3780_0000, 32'h0};

    initial begin
        logic        v;
        logic [31:0] d;
        int          n;
        b0.in_vld = 1'b0; b0.din = '0;
        b16.in_vld = 1'b0; b16.din = '0;
        repeat (2) @(negedge clk);
        chk("rst_vld0", 32'(b0.out_vld), 32'd0);
        chk("rst_dout0", b0.dout, 32'h0);
        chk("rst_vld16", 32'(b16.out_vld), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 11; i++)
            send(1'b1, d0v[i], e0v[i], i < 4, d16v[i & 3], e16v[i & 3]);
        for (int i = 0; i < 100; i++) begin
            v = 1'($urandom_range(0, 1));
            d = $urandom;
            if (i % 17 == 0) d = d >> $urandom_range(0, 31);
            send(v, d, ref_fp(d, 0), v, d, ref_fp(d, 16));
        end
        repeat (6) send(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            b0.in_vld = 1'b1; b0.din = 32'd7 + 32'(i);
            b16.in_vld = 1'b1; b16.din = 32'h0003_0000;
        end
        @(posedge clk);
        #1;
        b0.in_vld = 1'b0; b16.in_vld = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_vld0", 32'(b0.out_vld), 32'd0);
            chk("midrst_dout0", b0.dout, 32'h0);
            chk("midrst_vld16", 32'(b16.out_vld), 32'd0);
            chk("midrst_dout16", b16.dout, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) send(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        send(1'b1, 32'd3, 32'h4040_0000, 1'b1, 32'h0002_0000, 32'h4000_0000);
        send(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while ((q0.size() != 0 || q16.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q16", 32'(q16.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
